// File: rtl/fetch_queue_dual.sv
// Dual-issue instruction prefetch queue: sequential fetch with credits,
// circular word buffer, two-wide head presentation and redirect flush.
module fetch_queue_dual #(
    parameter int unsigned DEPTH    = 12,
    parameter int unsigned MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [31:0]                  mem_rdata,
    input  logic [1:0]                   consume,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         valid0,
    output logic                         valid1,
    output logic [31:0]                  instruction0,
    output logic [31:0]                  instruction1,
    output logic [31:0]                  pc0,
    output logic [31:0]                  pc1,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   data_q [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW-1:0] head1;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] disc_q, disc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tgt_pc;
    logic [31:0]   credit;
    logic [1:0]    req_pop;
    logic [1:0]    pops;
    logic          grant;
    logic          push;
    logic          unused_pc_bits;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] idx,
                                               input logic [1:0]    n);
        logic [IW:0] s;
        s = (IW+1)'(idx) + (IW+1)'(n);
        if (s >= (IW+1)'(DEPTH)) begin
            s = s - (IW+1)'(DEPTH);
        end
        return s[IW-1:0];
    endfunction

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign tgt_pc         = {redirect_pc[31:2], 2'b00};

    always_comb begin
        req_pop = (consume == 2'd3) ? 2'd2 : consume;
        pops    = req_pop;
        if (CW'(req_pop) > count_q) begin
            pops = 2'(count_q);
        end
    end

    // Credits cover stored words plus every in-flight response, stale or not.
    assign credit  = 32'(count_q) + 32'(outst_q) - 32'(pops);
    assign mem_req = !rst && !redirect && (credit < DEPTH)
                     && (32'(outst_q) < MAX_OUT);
    assign grant   = mem_req && mem_gnt;
    assign push    = mem_rvalid && (disc_q == '0) && !redirect;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        if (redirect) begin
            count_d = '0;
            head_d  = tail_q;
            pc_d    = tgt_pc;
            addr_d  = tgt_pc;
            outst_d = outst_q - OW'(mem_rvalid);
            disc_d  = outst_q - OW'(mem_rvalid);
        end else begin
            head_d  = wrap_add(head_q, pops);
            pc_d    = pc_q + (32'(pops) << 2);
            count_d = count_q + CW'(push) - CW'(pops);
            if (push) begin
                tail_d = wrap_add(tail_q, 2'd1);
            end
            if (grant) begin
                addr_d = addr_q + 32'd4;
            end
            outst_d = outst_q + OW'(grant) - OW'(mem_rvalid);
            if (mem_rvalid && (disc_q != '0)) begin
                disc_d = disc_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
            disc_q  <= '0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= mem_rdata;
        end
    end

    assign head1        = wrap_add(head_q, 2'd1);
    assign valid0       = (count_q != '0);
    assign valid1       = (count_q >= CW'(2));
    assign instruction0 = valid0 ? data_q[head_q] : '0;
    assign instruction1 = valid1 ? data_q[head1] : '0;
    assign pc0          = pc_q;
    assign pc1          = pc_q + 32'd4;
    assign count        = count_q;
    assign mem_addr     = addr_q;

endmodule

// File: tb/tb_fetch_queue_dual.sv
// Bench for fetch_queue_dual: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_queue_dual;

    localparam int DEPTH   = 12;
    localparam int MAX_OUT = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  consume;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid0;
    logic        valid1;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [3:0]  count;

    fetch_queue_dual #(
        .DEPTH(DEPTH),
        .MAX_OUT(MAX_OUT),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .consume(consume),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .valid0(valid0),
        .valid1(valid1),
        .instruction0(instruction0),
        .instruction1(instruction1),
        .pc0(pc0),
        .pc1(pc1),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: stored entries, fetch pointer, credits, bus queue.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    ent_t        mq[$];
    pend_t       bus[$];
    int          m_out;
    int          m_disc;
    logic [31:0] m_fpc;
    logic [31:0] m_hpc;
    int          cyc = 0;

    task automatic model_reset();
        mq.delete();
        bus.delete();
        m_out  = 0;
        m_disc = 0;
        m_fpc  = 32'h0;
        m_hpc  = 32'h0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_v0"}, valid0, 0);
        chk({tag, "_v1"}, valid1, 0);
        chk({tag, "_i0"}, instruction0, 0);
        chk({tag, "_i1"}, instruction1, 0);
        chk({tag, "_pc0"}, pc0, 32'h0);
        chk({tag, "_pc1"}, pc1, 32'h4);
        chk({tag, "_cnt"}, count, 0);
    endtask

    task automatic do_reset(input string tag);
        rst         = 1'b1;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        consume     = 2'd0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        check_reset(tag);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at negedge, compare against the model, advance both.
    task automatic step(input bit gnt, input int lat, input logic [1:0] cons,
                        input bit redir, input logic [31:0] rpc);
        bit          rv;
        bit          ereq;
        logic [31:0] rd;
        int          pops;
        int          n;
        @(negedge clk);
        rv = (bus.size() > 0) && (bus[0].due <= cyc);
        rd = rv ? bus[0].addr : 32'h0;
        mem_gnt     = gnt;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        consume     = cons;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        n    = mq.size();
        pops = (cons == 2'd3) ? 2 : int'(cons);
        if (pops > n) pops = n;
        ereq = !redir && (n + m_out - pops < DEPTH) && (m_out < MAX_OUT);
        chk("mem_req", mem_req, ereq);
        chk("mem_addr", mem_addr, m_fpc);
        chk("count", count, n);
        chk("valid0", valid0, n >= 1);
        chk("valid1", valid1, n >= 2);
        chk("pc0", pc0, (n > 0) ? mq[0].pc : m_hpc);
        chk("pc1", pc1, ((n > 0) ? mq[0].pc : m_hpc) + 32'd4);
        chk("instr0", instruction0, (n > 0) ? mq[0].w : 32'h0);
        chk("instr1", instruction1, (n > 1) ? mq[1].w : 32'h0);
        if (rv) void'(bus.pop_front());
        if (redir) begin
            if (rv) m_out--;
            m_disc = m_out;
            mq.delete();
            m_hpc = rpc & ~32'h3;
            m_fpc = rpc & ~32'h3;
        end else begin
            repeat (pops) begin
                void'(mq.pop_front());
                m_hpc += 32'd4;
            end
            if (rv) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else mq.push_back('{m_hpc + 32'(4 * mq.size()), rd});
            end
            if (ereq && gnt) begin
                bus.push_back('{m_fpc, cyc + lat});
                m_fpc += 32'd4;
                m_out++;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    typedef struct {
        bit          gnt;
        bit          rv;
        logic [31:0] rd;
        logic [1:0]  cons;
        bit          redir;
        logic [31:0] rpc;
        bit          req;
        logic [31:0] addr;
        int          cnt;
        bit          v0;
        bit          v1;
        logic [31:0] p0;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t        tv[11];
    logic [31:0] a_hold;
    bit          seen;

    initial begin
        tv[0]  = '{0, 0, 32'h0,  2'd0, 0, 32'h0,   1, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h0};
        tv[1]  = '{1, 0, 32'h0,  2'd0, 0, 32'h0,   1, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h0};
        tv[2]  = '{1, 0, 32'h0,  2'd0, 0, 32'h0,   1, 32'h4,   0, 0, 0, 32'h0,   32'h0,  32'h0};
        tv[3]  = '{0, 1, 32'h11, 2'd0, 0, 32'h0,   1, 32'h8,   0, 0, 0, 32'h0,   32'h0,  32'h0};
        tv[4]  = '{0, 1, 32'h22, 2'd0, 0, 32'h0,   1, 32'h8,   1, 1, 0, 32'h0,   32'h11, 32'h0};
        tv[5]  = '{1, 0, 32'h0,  2'd1, 0, 32'h0,   1, 32'h8,   2, 1, 1, 32'h0,   32'h11, 32'h22};
        tv[6]  = '{0, 0, 32'h0,  2'd3, 0, 32'h0,   1, 32'hC,   1, 1, 0, 32'h4,   32'h22, 32'h0};
        tv[7]  = '{1, 1, 32'h33, 2'd2, 1, 32'h103, 0, 32'hC,   0, 0, 0, 32'h8,   32'h0,  32'h0};
        tv[8]  = '{1, 0, 32'h0,  2'd0, 0, 32'h0,   1, 32'h100, 0, 0, 0, 32'h100, 32'h0,  32'h0};
        tv[9]  = '{0, 1, 32'h44, 2'd0, 0, 32'h0,   1, 32'h104, 0, 0, 0, 32'h100, 32'h0,  32'h0};
        tv[10] = '{0, 0, 32'h0,  2'd0, 0, 32'h0,   1, 32'h104, 1, 1, 0, 32'h100, 32'h44, 32'h0};

        do_reset("rst0");
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            mem_gnt     = tv[i].gnt;
            mem_rvalid  = tv[i].rv;
            mem_rdata   = tv[i].rd;
            consume     = tv[i].cons;
            redirect    = tv[i].redir;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("tv%0d_req", i), mem_req, tv[i].req);
            chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].addr);
            chk($sformatf("tv%0d_cnt", i), count, tv[i].cnt);
            chk($sformatf("tv%0d_v0", i), valid0, tv[i].v0);
            chk($sformatf("tv%0d_v1", i), valid1, tv[i].v1);
            chk($sformatf("tv%0d_pc0", i), pc0, tv[i].p0);
            chk($sformatf("tv%0d_i0", i), instruction0, tv[i].i0);
            chk($sformatf("tv%0d_i1", i), instruction1, tv[i].i1);
            @(posedge clk);
        end

        // Fill to capacity with no consumption.
        do_reset("rst1");
        repeat (30) step(1, 3, 2'd0, 0, 32'h0);
        #1;
        chk("fill_cnt", count, 12);
        chk("fill_req", mem_req, 0);
        chk("fill_i0", instruction0, 32'h0);
        chk("fill_i1", instruction1, 32'h4);

        // Drain two per cycle while refilling; head wraps several times.
        repeat (40) step(1, 3, 2'd2, 0, 32'h0);
        repeat (10) step(1, 2, 2'd1, 0, 32'h0);

        // Redirect with three requests in flight.
        do_reset("rst2");
        repeat (3) step(1, 5, 2'd0, 0, 32'h0);
        step(0, 5, 2'd0, 1, 32'h103);
        #1;
        chk("redir_cnt", count, 0);
        chk("redir_v0", valid0, 0);
        chk("redir_addr", mem_addr, 32'h100);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1, 5, 2'd0, 0, 32'h0);
            #1;
            seen = valid0;
        end
        chk("redir_seen", seen, 1);
        chk("redir_pc0", pc0, 32'h100);
        chk("redir_i0", instruction0, 32'h100);

        // Redirect coinciding with an arriving word and consume=2.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            seen = (bus.size() > 0) && (bus[0].due <= cyc) && (mq.size() >= 2);
            if (!seen) step(1, 3, 2'd0, 0, 32'h0);
        end
        chk("rv_redir_setup", seen, 1);
        step(1, 3, 2'd2, 1, 32'h206);
        #1;
        chk("rv_redir_cnt", count, 0);
        chk("rv_redir_pc0", pc0, 32'h204);
        repeat (20) step(1, 3, 2'd0, 0, 32'h0);

        // Grant withheld: address and credits must hold.
        repeat (3) step(1, 4, 2'd2, 0, 32'h0);
        #1;
        a_hold = mem_addr;
        repeat (5) step(0, 4, 2'd0, 0, 32'h0);
        #1;
        chk("stall_addr", mem_addr, a_hold);
        repeat (4) step(1, 2, 2'd1, 0, 32'h0);
        #3;
        do_reset("rst_mid");

        // Address wrap at 2^32.
        step(1, 2, 2'd0, 1, 32'hFFFF_FFF9);
        repeat (12) step(1, 2, 2'd1, 0, 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
            step($urandom_range(0, 9) < 7, $urandom_range(1, 5),
                 2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
